data_array_port_ctrl: RTL and testbench
=======================================

Name: data_array_port_ctrl

Overview:
- Requester-side controller for the 32-entry x 128-bit L1 data array: generates chip select, output enable, active-low byte write enables, address and write data, and consumes the array's read data.
- Arbitrates three clients:
  - core word read/write (32-bit);
  - AXI refill, which collects 4 x 32-bit beats and writes one full line;
  - writeback, which reads one line and streams it out as 4 x 32-bit beats.
- Sits between the cache controller/AXI master and the data array wrapper.

Parameters:
- IDX_W, 5, line index width (32 lines)
- LINE_W, 128, line width in bits
- WORD_W, 32, core/AXI beat width
- BEATS, 4, words per line (LINE_W/WORD_W)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous reset, active low
- core_req  in  1  core access request
- core_write  in  1  1=write, 0=read
- core_index  in  IDX_W  line index
- core_offset  in  2  word within line
- core_wstrb  in  4  byte strobes, active high
- core_wdata  in  WORD_W  write data
- core_ready  out  1  request accepted this cycle
- core_rvalid  out  1  read data valid (1-cycle pulse)
- core_rdata  out  WORD_W  read data
- fill_valid  in  1  refill beat valid
- fill_data  in  WORD_W  refill beat
- fill_index  in  IDX_W  target line; sampled on first beat
- fill_ready  out  1  beat accepted
- fill_done  out  1  1-cycle pulse after line write
- wb_req  in  1  writeback request (level, held until wb_valid seen)
- wb_index  in  IDX_W  line to read
- wb_valid  out  1  writeback beat valid
- wb_data  out  WORD_W  writeback beat
- wb_last  out  1  final beat
- wb_ready  in  1  downstream accepts beat
- DA_CS  out  1  array chip select
- DA_OE  out  1  array output enable
- DA_WEB  out  16  byte write enable, active low
- DA_A  out  IDX_W  array address
- DA_DI  out  LINE_W  array write data
- DA_DO  in  LINE_W  array read data

Behaviour:
- Reset (async, ARESETn low):
  - state=INIT;
  - DA_CS=0, DA_OE=0, DA_WEB=16'hFFFF, DA_A=0, DA_DI=0;
  - core_ready=0, core_rvalid=0, core_rdata=0;
  - fill_ready=0, fill_done=0;
  - wb_valid=0, wb_data=0, wb_last=0;
  - beat counter=0, line buffer=0.
- INIT -> IDLE on the first clock after reset release.
- Array timing: synchronous. An access is presented with DA_CS=1. Read = WEB all ones, OE=1; DA_DO is valid the following cycle and OE is held through that capture cycle. Write = WEB bytes low, completes at the presenting edge.
- Word k maps to DA_DI[32k+31:32k] and DA_WEB[4k+3:4k].
- IDLE priority: fill_valid > wb_req > core_req.
  - core_ready = IDLE & core_req & ~fill_valid & ~wb_req.
  - Core write: the same cycle drives DA_CS=1, DA_A=core_index, core_wdata replicated on all 4 words of DA_DI, DA_WEB[4k+3:4k]=~core_wstrb for k=core_offset and 1 elsewhere; stays IDLE. core_wstrb=0 yields WEB=all ones (no-op write, still acknowledged).
  - Core read: same cycle drives CS=1, OE=1; -> RD_CAP. Next cycle: capture DA_DO word[offset] into core_rdata, core_rvalid=1 for one cycle, -> IDLE.
- Fill:
  - In IDLE with fill_valid: fill_ready=1, latch fill_index, store beat 0 -> FILL.
  - FILL: fill_ready=1; each accepted beat stored at position cnt; cnt wraps after beat 3 (4th beat) -> FILL_WR.
  - FILL_WR: CS=1, WEB=16'h0000, DI=assembled line, A=latched index; fill_done=1 the next cycle; -> IDLE.
  - Core and writeback requests are not served from FILL until FILL_WR completes.
- Writeback:
  - IDLE with wb_req (no fill_valid): CS=1, OE=1, A=wb_index -> WB_CAP.
  - WB_CAP: latch DA_DO into the line buffer -> WB_SEND.
  - WB_SEND: wb_valid=1, wb_data=buffer word cnt, wb_last=(cnt==3). Advance only on wb_valid&wb_ready; data held stable while stalled. After the last handshake -> IDLE, cnt=0.
- Core request arriving during RD_CAP/FILL/WB: core_ready=0; the core holds its request.
- Mid-operation reset: abort immediately to INIT; a partially collected line is discarded with no array write.

Decomposition:
- Shared package: state enum (INIT, IDLE, RD_CAP, FILL, FILL_WR, WB_CAP, WB_SEND), BEATS/WORD_W/LINE_W constants, word-to-WEB/DI lane mapping function.
- Optional sub-module: line_beat_buf (4 x 32 register buffer with write/read pointer). Used by both FILL and WB_SEND; only one is active at a time.

Test Plan:
- Core write idx 5, offset 2, wstrb 4'b0011, wdata 32'hDEADBEEF -> same cycle CS=1, A=5, WEB=16'hFCFF; then core read idx 5 offset 2 -> rvalid 2 cycles after request, rdata[15:0]=16'hBEEF.
- Fill idx 9 with beats 11111111,22222222,33333333,44444444 (fill_valid gapped 1 cycle between beats) -> single array write, WEB=0, DI=128'h44444444_33333333_22222222_11111111, fill_done pulse; core read idx 9 offset 3 returns 44444444.
- Writeback idx 9 with wb_ready low 3 cycles at beat 1 -> beats in order 11111111..44444444, wb_data stable while stalled, wb_last only on beat 3.
- fill_valid, wb_req, core_req asserted in the same cycle -> fill served first, then writeback, then core (core_ready held 0 until IDLE with no other request).
- ARESETn low after 2 fill beats -> all outputs at reset values; subsequent read of that index shows the prior contents unchanged.
- Core read idx 31 offset 0, wstrb 0 write idx 31 -> WEB=16'hFFFF, core_ready=1, data unchanged.

Source files
------------

// File: rtl/data_array_port_ctrl_pkg.sv
// Shared types and lane helpers for the L1 data array port controller.
// Word k of a line lives in DI/DO bits [32k+31:32k] and WEB bits [4k+3:4k].
package data_array_port_ctrl_pkg;

  localparam int DA_IDX_W = 5;
  localparam int LINE_W   = 128;
  localparam int WORD_W   = 32;
  localparam int BEATS    = LINE_W / WORD_W;
  localparam int OFF_W    = $clog2(BEATS);
  localparam int STRB_W   = WORD_W / 8;
  localparam int WEB_W    = LINE_W / 8;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BEATS - 1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_CAP,
    FILL,
    FILL_WR,
    WB_CAP,
    WB_SEND
  } state_e;

  // Active-low byte enables: only the addressed word's strobed bytes go low.
  function automatic logic [WEB_W-1:0] lane_web(input logic [OFF_W-1:0]  off,
                                                input logic [STRB_W-1:0] strb);
    logic [WEB_W-1:0] web;
    web = '1;
    web[off*STRB_W +: STRB_W] = ~strb;
    return web;
  endfunction

  function automatic logic [LINE_W-1:0] lane_di(input logic [WORD_W-1:0] word);
    return {BEATS{word}};
  endfunction

  function automatic logic [WORD_W-1:0] lane_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  off);
    return line[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/data_array_port_ctrl_line_beat_buf.sv
// Four-word line buffer with a single beat pointer, shared by refill
// (beat-wise push, whole-line read) and writeback (line load, beat-wise pop).
module line_beat_buf
  import data_array_port_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              load_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] word_o,
  output logic [LINE_W-1:0] line_o,
  output logic [OFF_W-1:0]  ptr_o
);

  logic [WORD_W-1:0] words_q [BEATS];
  logic [OFF_W-1:0]  ptr_q;

  // NOTE: this buffer is a few flops, not an SRAM, so it is reset to a known
  // value like any other state; a real memory macro would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BEATS; k++) words_q[k] <= '0;
      ptr_q <= '0;
    end else if (load_i) begin
      for (int k = 0; k < BEATS; k++) words_q[k] <= line_i[k*WORD_W +: WORD_W];
      ptr_q <= '0;
    end else if (push_i) begin
      words_q[ptr_q] <= push_data_i;
      ptr_q          <= ptr_q + 1'b1;
    end else if (pop_i) begin
      ptr_q <= ptr_q + 1'b1;
    end
  end

  always_comb begin
    line_o = '0;
    for (int k = 0; k < BEATS; k++) line_o[k*WORD_W +: WORD_W] = words_q[k];
  end

  assign word_o = words_q[ptr_q];
  assign ptr_o  = ptr_q;

endmodule

// File: rtl/data_array_port_ctrl.sv
// Requester-side port controller for the 32 x 128-bit L1 data array.
// Arbitrates refill > writeback > core word access onto one synchronous port.
module data_array_port_ctrl
  import data_array_port_ctrl_pkg::*;
#(
  parameter int IDX_W = DA_IDX_W
) (
  input  logic              ACLK,
  input  logic              ARESETn,

  input  logic              core_req,
  input  logic              core_write,
  input  logic [IDX_W-1:0]  core_index,
  input  logic [OFF_W-1:0]  core_offset,
  input  logic [STRB_W-1:0] core_wstrb,
  input  logic [WORD_W-1:0] core_wdata,
  output logic              core_ready,
  output logic              core_rvalid,
  output logic [WORD_W-1:0] core_rdata,

  input  logic              fill_valid,
  input  logic [WORD_W-1:0] fill_data,
  input  logic [IDX_W-1:0]  fill_index,
  output logic              fill_ready,
  output logic              fill_done,

  input  logic              wb_req,
  input  logic [IDX_W-1:0]  wb_index,
  output logic              wb_valid,
  output logic [WORD_W-1:0] wb_data,
  output logic              wb_last,
  input  logic              wb_ready,

  output logic              DA_CS,
  output logic              DA_OE,
  output logic [WEB_W-1:0]  DA_WEB,
  output logic [IDX_W-1:0]  DA_A,
  output logic [LINE_W-1:0] DA_DI,
  input  logic [LINE_W-1:0] DA_DO
);

  state_e            state_q;
  logic [IDX_W-1:0]  fill_idx_q;
  logic [OFF_W-1:0]  rd_off_q;
  logic [WORD_W-1:0] core_rdata_q;
  logic              core_rvalid_q;
  logic              fill_done_q;

  logic              in_idle;
  logic              wb_go;
  logic              core_go;
  logic              buf_push;
  logic              buf_load;
  logic              buf_pop;
  logic [WORD_W-1:0] buf_word;
  logic [LINE_W-1:0] buf_line;
  logic [OFF_W-1:0]  beat_ptr;

  assign in_idle = (state_q == IDLE);
  assign wb_go   = in_idle & ~fill_valid & wb_req;
  assign core_go = in_idle & ~fill_valid & ~wb_req & core_req;

  assign core_ready  = core_go;
  assign core_rvalid = core_rvalid_q;
  assign core_rdata  = core_rdata_q;

  assign fill_ready = in_idle | (state_q == FILL);
  assign fill_done  = fill_done_q;

  assign wb_valid = (state_q == WB_SEND);
  assign wb_data  = buf_word;
  assign wb_last  = wb_valid & (beat_ptr == LAST_BEAT);

  assign buf_push = fill_valid & fill_ready;
  assign buf_load = (state_q == WB_CAP);
  assign buf_pop  = wb_valid & wb_ready;

  line_beat_buf u_line_beat_buf (
    .clk         (ACLK),
    .rst_n       (ARESETn),
    .push_i      (buf_push),
    .push_data_i (fill_data),
    .load_i      (buf_load),
    .line_i      (DA_DO),
    .pop_i       (buf_pop),
    .word_o      (buf_word),
    .line_o      (buf_line),
    .ptr_o       (beat_ptr)
  );

  // Array port is driven in the same cycle a request wins arbitration.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    DA_CS  = 1'b0;
    DA_OE  = 1'b0;
    DA_WEB = '1;
    DA_A   = '0;
    DA_DI  = '0;
    unique case (state_q)
      IDLE: begin
        if (wb_go) begin
          DA_CS = 1'b1;
          DA_OE = 1'b1;
          DA_A  = wb_index;
        end else if (core_go) begin
          DA_CS = 1'b1;
          DA_A  = core_index;
          if (core_write) begin
            DA_DI  = lane_di(core_wdata);
            DA_WEB = lane_web(core_offset, core_wstrb);
          end else begin
            DA_OE = 1'b1;
          end
        end
      end
      RD_CAP, WB_CAP: DA_OE = 1'b1;
      FILL_WR: begin
        DA_CS  = 1'b1;
        DA_WEB = '0;
        DA_A   = fill_idx_q;
        DA_DI  = buf_line;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q       <= INIT;
      fill_idx_q    <= '0;
      rd_off_q      <= '0;
      core_rdata_q  <= '0;
      core_rvalid_q <= 1'b0;
      fill_done_q   <= 1'b0;
    end else begin
      core_rvalid_q <= 1'b0;
      fill_done_q   <= 1'b0;
      unique case (state_q)
        INIT: state_q <= IDLE;
        IDLE: begin
          if (fill_valid) begin
            fill_idx_q <= fill_index;
            state_q    <= FILL;
          end else if (wb_req) begin
            state_q <= WB_CAP;
          end else if (core_req && !core_write) begin
            rd_off_q <= core_offset;
            state_q  <= RD_CAP;
          end
        end
        RD_CAP: begin
          core_rdata_q  <= lane_word(DA_DO, rd_off_q);
          core_rvalid_q <= 1'b1;
          state_q       <= IDLE;
        end
        FILL: begin
          if (fill_valid && beat_ptr == LAST_BEAT) state_q <= FILL_WR;
        end
        FILL_WR: begin
          fill_done_q <= 1'b1;
          state_q     <= IDLE;
        end
        WB_CAP: state_q <= WB_SEND;
        WB_SEND: begin
          if (wb_ready && beat_ptr == LAST_BEAT) state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_array_port_ctrl.sv
// Directed bench for data_array_port_ctrl with a behavioural synchronous
// 32 x 128 array model; expected values are hand-derived constants.
module tb_data_array_port_ctrl;

  logic         ACLK;
  logic         ARESETn;
  logic         core_req, core_write;
  logic [4:0]   core_index;
  logic [1:0]   core_offset;
  logic [3:0]   core_wstrb;
  logic [31:0]  core_wdata;
  logic         core_ready, core_rvalid;
  logic [31:0]  core_rdata;
  logic         fill_valid;
  logic [31:0]  fill_data;
  logic [4:0]   fill_index;
  logic         fill_ready, fill_done;
  logic         wb_req;
  logic [4:0]   wb_index;
  logic         wb_valid, wb_last, wb_ready;
  logic [31:0]  wb_data;
  logic         DA_CS, DA_OE;
  logic [15:0]  DA_WEB;
  logic [4:0]   DA_A;
  logic [127:0] DA_DI, DA_DO;

  int n_vec = 0;
  int n_err = 0;

  data_array_port_ctrl dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .core_req(core_req), .core_write(core_write), .core_index(core_index),
    .core_offset(core_offset), .core_wstrb(core_wstrb), .core_wdata(core_wdata),
    .core_ready(core_ready), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_index(fill_index),
    .fill_ready(fill_ready), .fill_done(fill_done),
    .wb_req(wb_req), .wb_index(wb_index), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_last(wb_last), .wb_ready(wb_ready),
    .DA_CS(DA_CS), .DA_OE(DA_OE), .DA_WEB(DA_WEB), .DA_A(DA_A),
    .DA_DI(DA_DI), .DA_DO(DA_DO)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Synchronous array: byte writes at the presenting edge, read data next cycle.
  logic [127:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = {4{32'h12345678}};
    DA_DO = '0;
    forever begin
      @(posedge ACLK);
      if (DA_CS) begin
        if (DA_WEB != 16'hFFFF) begin
          for (int b = 0; b < 16; b++)
            if (!DA_WEB[b]) mem[DA_A][b*8 +: 8] <= DA_DI[b*8 +: 8];
        end else if (DA_OE) begin
          DA_DO <= mem[DA_A];
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_cs", DA_CS, 0);
    check("rst_oe", DA_OE, 0);
    check("rst_web", DA_WEB, 16'hFFFF);
    check("rst_a", DA_A, 0);
    check("rst_di", DA_DI, 0);
    check("rst_core_ready", core_ready, 0);
    check("rst_rvalid", core_rvalid, 0);
    check("rst_rdata", core_rdata, 0);
    check("rst_fill_ready", fill_ready, 0);
    check("rst_fill_done", fill_done, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_last", wb_last, 0);
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [1:0] off, input logic [3:0] strb,
                          input logic [31:0] d, input logic [15:0] exp_web);
    core_req = 1; core_write = 1; core_index = idx; core_offset = off;
    core_wstrb = strb; core_wdata = d;
    #3;
    check("wr_ready", core_ready, 1);
    check("wr_cs", DA_CS, 1);
    check("wr_a", DA_A, idx);
    check("wr_web", DA_WEB, exp_web);
    check("wr_di", DA_DI, {4{d}});
    tick();
    core_req = 0; core_write = 0;
  endtask

  task automatic do_read(input logic [4:0] idx, input logic [1:0] off, input logic [31:0] exp);
    core_req = 1; core_write = 0; core_index = idx; core_offset = off;
    #3;
    check("rd_ready", core_ready, 1);
    check("rd_cs", DA_CS, 1);
    check("rd_oe", DA_OE, 1);
    check("rd_a", DA_A, idx);
    check("rd_web", DA_WEB, 16'hFFFF);
    tick();
    core_req = 0;
    #3;
    check("rd_cap_oe", DA_OE, 1);
    check("rd_cap_rvalid", core_rvalid, 0);
    tick();
    check("rd_rvalid", core_rvalid, 1);
    check("rd_rdata", core_rdata, exp);
    tick();
    check("rd_rvalid_pulse", core_rvalid, 0);
  endtask

  task automatic fill_beat(input logic [31:0] d, input logic [4:0] idx);
    fill_valid = 1; fill_data = d; fill_index = idx;
    #3;
    check("fill_ready", fill_ready, 1);
    tick();
    fill_valid = 0;
  endtask

  logic [127:0] exp_line;
  logic [31:0]  exp_word;
  logic [31:0]  wb5 [4];

  initial begin
    ARESETn = 0;
    core_req = 1; core_write = 0; core_index = 0; core_offset = 0;
    core_wstrb = 0; core_wdata = 0;
    fill_valid = 0; fill_data = 0; fill_index = 0;
    wb_req = 0; wb_index = 0; wb_ready = 0;

    // Reset state, with a core request pending that must not be acknowledged.
    repeat (3) @(posedge ACLK);
    #1;
    check_reset_outputs();
    core_req = 0;
    ARESETn = 1;
    #3;
    check("init_fill_ready", fill_ready, 0);
    tick();

    // Partial-strobe core write, then read it back.
    do_write(5'd5, 2'd2, 4'b0011, 32'hDEADBEEF, 16'hFCFF);
    do_read(5'd5, 2'd2, 32'h1234BEEF);

    // Gapped refill of line 9; fill_index is only honoured on beat 0.
    exp_line = '0;
    for (int b = 0; b < 4; b++) begin
      exp_word = 32'h11111111 * (b + 1);
      exp_line[b*32 +: 32] = exp_word;
      fill_beat(exp_word, (b == 0) ? 5'd9 : 5'd0);
      if (b < 3) begin
        #3;
        check("fill_gap_cs", DA_CS, 0);
        tick();
      end
    end
    #3;
    check("fillwr_cs", DA_CS, 1);
    check("fillwr_web", DA_WEB, 16'h0000);
    check("fillwr_a", DA_A, 9);
    check("fillwr_di", DA_DI, 128'h44444444_33333333_22222222_11111111);
    check("fillwr_ready", fill_ready, 0);
    tick();
    check("fill_done", fill_done, 1);
    tick();
    check("fill_done_pulse", fill_done, 0);
    do_read(5'd9, 2'd3, 32'h44444444);

    // Writeback of line 9 with a 3-cycle stall on beat 1.
    wb_req = 1; wb_index = 9; wb_ready = 0;
    #3;
    check("wb_rd_cs", DA_CS, 1);
    check("wb_rd_oe", DA_OE, 1);
    check("wb_rd_a", DA_A, 9);
    tick();
    #3;
    check("wb_cap_oe", DA_OE, 1);
    check("wb_cap_cs", DA_CS, 0);
    check("wb_cap_valid", wb_valid, 0);
    tick();
    wb_req = 0;
    for (int b = 0; b < 4; b++) begin
      exp_word = 32'h11111111 * (b + 1);
      for (int s = 0; s < ((b == 1) ? 3 : 0); s++) begin
        wb_ready = 0;
        #3;
        check("wb_stall_valid", wb_valid, 1);
        check("wb_stall_data", wb_data, exp_word);
        check("wb_stall_last", wb_last, 0);
        tick();
      end
      wb_ready = 1;
      #3;
      check("wb_valid", wb_valid, 1);
      check("wb_data", wb_data, exp_word);
      check("wb_last", wb_last, (b == 3));
      tick();
    end
    wb_ready = 0;
    check("wb_done_valid", wb_valid, 0);

    // All three requesters at once: fill, then writeback, then core.
    wb5[0] = 32'h12345678; wb5[1] = 32'h12345678;
    wb5[2] = 32'h1234BEEF; wb5[3] = 32'h12345678;
    wb_req = 1; wb_index = 5;
    core_req = 1; core_write = 0; core_index = 9; core_offset = 3;
    exp_line = '0;
    for (int b = 0; b < 4; b++) begin
      exp_word = 32'hA0A0A0A0 + 32'h01010101 * b;
      exp_line[b*32 +: 32] = exp_word;
      fill_valid = 1; fill_data = exp_word; fill_index = (b == 0) ? 5'd3 : 5'd0;
      #3;
      check("pri_fill_ready", fill_ready, 1);
      check("pri_core_blocked_fill", core_ready, 0);
      check("pri_no_array_during_fill", DA_CS, 0);
      tick();
    end
    fill_valid = 0;
    #3;
    check("pri_fillwr_cs", DA_CS, 1);
    check("pri_fillwr_web", DA_WEB, 16'h0000);
    check("pri_fillwr_a", DA_A, 3);
    check("pri_fillwr_di", DA_DI, exp_line);
    check("pri_core_blocked_fillwr", core_ready, 0);
    tick();
    check("pri_fill_done", fill_done, 1);
    #2;
    check("pri_core_blocked_wb", core_ready, 0);
    check("pri_wb_cs", DA_CS, 1);
    check("pri_wb_oe", DA_OE, 1);
    check("pri_wb_a", DA_A, 5);
    tick();
    #3;
    check("pri_core_blocked_cap", core_ready, 0);
    tick();
    wb_req = 0; wb_ready = 1;
    for (int b = 0; b < 4; b++) begin
      #3;
      check("pri_wb_data", wb_data, wb5[b]);
      check("pri_core_blocked_send", core_ready, 0);
      tick();
    end
    wb_ready = 0;
    #3;
    check("pri_core_ready", core_ready, 1);
    check("pri_core_oe", DA_OE, 1);
    check("pri_core_a", DA_A, 9);
    tick();
    core_req = 0;
    tick();
    check("pri_core_rvalid", core_rvalid, 1);
    check("pri_core_rdata", core_rdata, 32'h44444444);
    tick();
    do_read(5'd3, 2'd1, 32'hA1A1A1A1);

    // Reset after two refill beats: no array write, line 9 untouched.
    fill_beat(32'hDEAD0001, 5'd9);
    fill_beat(32'hDEAD0002, 5'd9);
    ARESETn = 0;
    #1;
    check_reset_outputs();
    tick();
    #2;
    check("rst_hold_cs", DA_CS, 0);
    tick();
    ARESETn = 1;
    tick();
    do_read(5'd9, 2'd3, 32'h44444444);
    do_read(5'd9, 2'd0, 32'h11111111);

    // Zero-strobe write to line 31 is acknowledged but changes nothing.
    do_read(5'd31, 2'd0, 32'h12345678);
    do_write(5'd31, 2'd0, 4'b0000, 32'hFFFFFFFF, 16'hFFFF);
    do_read(5'd31, 2'd0, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
